// File: rtl/paper_vend_ctrl.sv
// paper_vend_ctrl: multi-item coin vending controller.
// Collects coin credit, tracks per-item stock, releases one item per accepted
// buy and pays change back as single-unit hopper pulses.
// Optional build macro: VEND_TIMEOUT_EN adds an inactivity timer that refunds
// credit left idle for TIMEOUT_CYCLES cycles.
module paper_vend_ctrl #(
    parameter int unsigned N_ITEMS        = 4,
    parameter int unsigned PRICE          = 3,
    parameter int unsigned CREDIT_W       = 5,
    parameter int unsigned STOCK_W        = 4,
    parameter int unsigned STOCK_INIT     = 8,
    parameter int unsigned HOLD_CYCLES    = 20,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    localparam int unsigned SEL_W         = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          coin,
    input  logic [SEL_W-1:0]    sel,
    input  logic                buy,
    input  logic                cancel,
    input  logic                restock,
    output logic [N_ITEMS-1:0]  vend_out,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic                sold_out,
    output logic [CREDIT_W-1:0] credit,
    output logic [N_ITEMS-1:0]  empty,
    output logic                busy
);

    localparam int unsigned CREDIT_MAX = (1 << CREDIT_W) - 1;
    // Wide enough for credit + 5 without wrapping, even for tiny CREDIT_W.
    localparam int unsigned SUM_W      = CREDIT_W + 3;
    localparam int unsigned HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StVend   = 2'b01,
        StChange = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [STOCK_W-1:0]  stock_q [N_ITEMS];
    logic [STOCK_W-1:0]  stock_d [N_ITEMS];
    logic [1:0]          coin_q;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    // High during the low half of a change pulse pair.
    logic                phase_q, phase_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sold_out_q, sold_out_d;

    logic                coin_edge;
    logic [SUM_W-1:0]    coin_val;
    logic                sel_ok;
    logic [STOCK_W-1:0]  stock_sel;
    logic                cancel_ok;
    logic                buy_ok;
    logic [SUM_W-1:0]    base;
    logic [SUM_W-1:0]    sum;

`ifdef VEND_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

    // Selects beyond the last item are never honoured.
    if (N_ITEMS == (1 << SEL_W)) begin : g_sel_full
        assign sel_ok = 1'b1;
    end else begin : g_sel_part
        assign sel_ok = (sel < SEL_W'(N_ITEMS));
    end

    // Coin edge detect, coin value decode and selected-item stock lookup.
    always_comb begin
        coin_edge = (coin != 2'b00) && (coin_q == 2'b00);
        case (coin)
            2'b01:   coin_val = SUM_W'(1);
            2'b10:   coin_val = SUM_W'(2);
            2'b11:   coin_val = SUM_W'(5);
            default: coin_val = '0;
        endcase
        stock_sel = sel_ok ? stock_q[sel] : '0;
    end

    // Next-state logic: credit, stock, vend hold timer and change pacing.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        stock_d       = stock_q;
        sel_d         = sel_q;
        hold_d        = hold_q;
        phase_d       = phase_q;
        coin_reject_d = 1'b0;
        sold_out_d    = 1'b0;
        cancel_ok     = 1'b0;
        buy_ok        = 1'b0;
        base          = SUM_W'(credit_q);
        sum           = '0;
`ifdef VEND_TIMEOUT_EN
        idle_cnt_d    = '0;
`endif
        case (state_q)
            StIdle: begin
                cancel_ok = cancel && (credit_q != '0);
                if (cancel_ok) begin
                    state_d = StChange;
                    phase_d = 1'b0;
                end else if (buy && sel_ok) begin
                    // Checks use pre-coin credit and pre-restock stock.
                    if (stock_sel == '0) begin
                        sold_out_d = 1'b1;
                    end else if (credit_q >= PRICE_C) begin
                        buy_ok = 1'b1;
                    end
                end
                if (buy_ok) begin
                    base    = SUM_W'(credit_q) - SUM_W'(PRICE);
                    sel_d   = sel;
                    hold_d  = '0;
                    state_d = StVend;
                end
                sum = base + coin_val;
                if (coin_edge && (cancel_ok || (sum > SUM_W'(CREDIT_MAX)))) begin
                    coin_reject_d = 1'b1;
                    credit_d      = base[CREDIT_W-1:0];
                end else if (coin_edge) begin
                    credit_d = sum[CREDIT_W-1:0];
                end else begin
                    credit_d = base[CREDIT_W-1:0];
                end
                for (int i = 0; i < N_ITEMS; i++) begin
                    if (restock) begin
                        stock_d[i] = STOCK_W'(STOCK_INIT);
                    end
                    if (buy_ok && (sel == SEL_W'(i))) begin
                        stock_d[i] = stock_d[i] - STOCK_W'(1);
                    end
                end
`ifdef VEND_TIMEOUT_EN
                if (!(coin_edge || buy || cancel) && (credit_q != '0)) begin
                    if (idle_cnt_q == TO_LAST) begin
                        state_d = StChange;
                        phase_d = 1'b0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + TO_W'(1);
                    end
                end
`endif
            end
            StVend: begin
                coin_reject_d = coin_edge;
                if (hold_q == HOLD_LAST) begin
                    hold_d  = '0;
                    phase_d = 1'b0;
                    state_d = (credit_q != '0) ? StChange : StIdle;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            StChange: begin
                coin_reject_d = coin_edge;
                if (credit_q == '0) begin
                    state_d = StIdle;
                end else if (!phase_q) begin
                    credit_d = credit_q - CREDIT_W'(1);
                    phase_d  = 1'b1;
                    if (credit_q == CREDIT_W'(1)) begin
                        state_d = StIdle;
                    end
                end else begin
                    phase_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; coin_q resets to 11 so a coin held through reset is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            credit_q      <= '0;
            coin_q        <= 2'b11;
            sel_q         <= '0;
            hold_q        <= '0;
            phase_q       <= 1'b0;
            coin_reject_q <= 1'b0;
            sold_out_q    <= 1'b0;
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            coin_q        <= coin;
            sel_q         <= sel_d;
            hold_q        <= hold_d;
            phase_q       <= phase_d;
            coin_reject_q <= coin_reject_d;
            sold_out_q    <= sold_out_d;
            stock_q       <= stock_d;
        end
    end

`ifdef VEND_TIMEOUT_EN
    // Inactivity counter; held at zero outside IDLE so it restarts on re-entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`endif

    // Outputs decoded from registered state only.
    always_comb begin
        vend_out = '0;
        if (state_q == StVend) begin
            vend_out[sel_q] = 1'b1;
        end
        change_pulse = (state_q == StChange) && !phase_q;
        busy         = (state_q != StIdle);
        credit       = credit_q;
        coin_reject  = coin_reject_q;
        sold_out     = sold_out_q;
        for (int i = 0; i < N_ITEMS; i++) begin
            empty[i] = (stock_q[i] == '0);
        end
    end

endmodule
